udma_hyper_ch_sched: RTL and testbench
======================================

// Module: udma_hyper_ch_sched
// PURPOSE
//  Round-robin scheduler that picks the next uDMA channel allowed to start a HyperBus transaction.
//  Consumes the per-channel busy vector (one-hot OR of the unpack and ctrl stage IDs).
//  Drives a registered valid/ready transaction-ID to the controller front end.
//  Tracks one outstanding transaction per channel until the controller reports it done.
// PARAMETERS
//  NB_CH     2  number of uDMA channels (>=2)
//  ID_WIDTH  1  trans ID width is ID_WIDTH+1 bits, same as the busy-vector generator; 2**(ID_WIDTH+1) >= NB_CH
// PORTS
//  clk_i            in   1           single clock; all logic rising-edge
//  rst_i            in   1           synchronous reset, active-high
//  ch_req_i         in   NB_CH       per-channel request; level, held until matching ch_ack_o
//  ch_ack_o         out  NB_CH       one-cycle pulse: that channel's request was issued
//  proc_id_vec_i    in   NB_CH       channels busy in the unpack/ctrl stages (one-hot OR)
//  trans_valid_o    out  1           transaction ID valid to controller
//  trans_ready_i    in   1           controller accepts ID
//  trans_id_o       out  ID_WIDTH+1  granted channel index
//  trans_done_i     in   1           one-cycle pulse: a transaction completed
//  trans_done_id_i  in   ID_WIDTH+1  channel index of the completed transaction
//  outstanding_o    out  NB_CH       channels issued but not yet done
//  spurious_done_o  out  1           one-cycle pulse: done for a channel not outstanding, or index >= NB_CH
// BEHAVIOUR
//  Reset (sync, rst_i=1 at edge)
//   - Outputs: trans_valid_o=0, trans_id_o=0, ch_ack_o=0, outstanding_o=0, spurious_done_o=0.
//   - State=IDLE, rr_ptr=0. A transaction in flight is dropped silently; no ack is produced.
//  Eligibility
//   - elig = ch_req_i & ~proc_id_vec_i & ~outstanding_q.
//  FSM IDLE
//   - If elig!=0: pick the first set bit scanning rr_ptr, rr_ptr+1, ... mod NB_CH.
//   - Register the pick into trans_id_o; set trans_valid_o=1 next cycle; go ISSUE.
//   - If elig==0: stay in IDLE.
//  FSM ISSUE
//   - trans_valid_o=1 and trans_id_o are held stable until trans_ready_i=1.
//   - Changes on ch_req_i or proc_id_vec_i do not cancel or alter the pending issue.
//  Handshake (ISSUE with trans_ready_i=1)
//   - ch_ack_o[id] pulses in the same cycle as the handshake.
//   - outstanding_q[id] is set at the edge; rr_ptr becomes (id+1) mod NB_CH.
//   - State returns to IDLE with trans_valid_o=0.
//   - Minimum issue spacing is 2 cycles; request-to-valid latency is 1 cycle.
//  Done
//   - trans_done_i with a valid index whose outstanding bit is set: clear that bit at the edge.
//   - Any other done (bit not set, or index >= NB_CH): no state change; spurious_done_o pulses next cycle.
//  Simultaneous events
//   - Done for channel A and handshake for channel B in the same cycle: both take effect.
//   - A==B cannot occur, because B was not outstanding when granted.
//   - A done that clears a bit in cycle t makes that channel eligible in IDLE from cycle t+1.
//  Outputs
//   - outstanding_o = outstanding_q (registered).
//   - All outputs are registered except ch_ack_o, which is decoded from ISSUE & trans_ready_i & id.
// TESTING
//  1. NB_CH=4; req=4'b1111, busy=0, ready=1 -> IDs 0,1,2,3 issued on cycles 1,3,5,7; outstanding=4'b1111; no further valid.
//  2. req=4'b0101, busy=4'b0001, rr_ptr=0 -> first issue is ID 2; ch_ack_o=4'b0100 pulsed for 1 cycle.
//  3. ISSUE with ID 1 and ready=0 for 5 cycles while req[1] drops and busy[1] rises -> valid and id=1 held; accepted on the 6th cycle.
//  4. outstanding=4'b0010; done id=1 in the same cycle as handshake id=3 -> outstanding=4'b1000 next cycle.
//  5. done id=2 while not outstanding, then done id=5 with NB_CH=4 -> spurious_done_o pulses twice; outstanding unchanged.
//  6. rst_i=1 for one cycle during ISSUE with outstanding=4'b0011 -> next cycle valid=0, outstanding=0, rr_ptr=0, no ack.

Source files
------------

// File: rtl/udma_hyper_ch_sched.sv
// ---------------------------------------------------------------------------
// udma_hyper_ch_sched
//   Round-robin scheduler that picks the next uDMA channel allowed to start a
//   HyperBus transaction. A channel is eligible when it requests, is not busy
//   in the unpack/ctrl stages and has no transaction outstanding. The winning
//   channel index is offered to the controller on a registered valid/ready
//   port. Each channel may have one transaction outstanding, which is cleared
//   when the controller reports it done.
//
// Ports
//   clk_i            single clock, rising edge
//   rst_i            synchronous reset, active high
//   ch_req_i         per-channel request level, held until ch_ack_o
//   ch_ack_o         one-cycle pulse when that channel's request is issued
//   proc_id_vec_i    channels busy in the unpack/ctrl stages
//   trans_valid_o    transaction ID valid to the controller
//   trans_ready_i    controller accepts the ID
//   trans_id_o       granted channel index
//   trans_done_i     one-cycle pulse: a transaction completed
//   trans_done_id_i  channel index of the completed transaction
//   outstanding_o    channels issued but not yet done
//   spurious_done_o  one-cycle pulse: done for a channel that was not
//                    outstanding, or for an index outside the channel range
// ---------------------------------------------------------------------------
module udma_hyper_ch_sched #(
    parameter int NB_CH    = 2,
    parameter int ID_WIDTH = 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [NB_CH-1:0]    ch_req_i,
    output logic [NB_CH-1:0]    ch_ack_o,
    input  logic [NB_CH-1:0]    proc_id_vec_i,
    output logic                trans_valid_o,
    input  logic                trans_ready_i,
    output logic [ID_WIDTH:0]   trans_id_o,
    input  logic                trans_done_i,
    input  logic [ID_WIDTH:0]   trans_done_id_i,
    output logic [NB_CH-1:0]    outstanding_o,
    output logic                spurious_done_o
);

    // state    | meaning
    // ST_IDLE  | no ID offered; pick an eligible channel when one appears
    // ST_ISSUE | trans_id_o offered with valid, held until trans_ready_i

    localparam int IDW = ID_WIDTH + 1;
    // One extra bit so NB_CH itself is representable (NB_CH may be 2**IDW).
    localparam logic [IDW:0] LP_NB_CH = (IDW+1)'(NB_CH);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [IDW-1:0]   r_trans_id;
    logic [IDW-1:0]   r_rr_ptr;
    logic             r_trans_valid;
    logic [NB_CH-1:0] r_outstanding;
    logic             r_spurious;

    logic [NB_CH-1:0] w_elig;
    logic [NB_CH-1:0] w_elig_rot;
    logic             w_pick_found;
    logic [IDW:0]     w_pick_off;
    logic [IDW:0]     w_pick_sum;
    logic [IDW-1:0]   w_pick;
    logic [IDW:0]     w_rr_sum;

    logic             w_handshake;
    logic [NB_CH-1:0] w_ack;
    logic [NB_CH-1:0] w_done_hot;
    logic             w_done_valid;

    logic             w_valid_nxt;
    logic [IDW-1:0]   w_id_nxt;
    logic [IDW-1:0]   w_rr_nxt;
    logic [NB_CH-1:0] w_out_nxt;
    logic             w_spurious_nxt;

    assign w_elig = ch_req_i & ~proc_id_vec_i & ~r_outstanding;

    // Rotate the eligibility vector so bit 0 is the channel at rr_ptr; the
    // lowest set bit of the rotated vector is then the round-robin winner.
    assign w_elig_rot = NB_CH'({w_elig, w_elig} >> r_rr_ptr);

    always_comb begin
        w_pick_found = 1'b0;
        w_pick_off   = '0;
        for (int i = NB_CH - 1; i >= 0; i--) begin
            if (w_elig_rot[i]) begin
                w_pick_found = 1'b1;
                w_pick_off   = (IDW+1)'(i);
            end
        end
        w_pick_sum = {1'b0, r_rr_ptr} + w_pick_off;
        if (w_pick_sum >= LP_NB_CH) begin
            w_pick_sum = w_pick_sum - LP_NB_CH;
        end
        w_pick = w_pick_sum[IDW-1:0];
    end

    // Gated by reset so a transaction dropped by reset never acks.
    assign w_handshake = (r_state == ST_ISSUE) && trans_ready_i && !rst_i;

    always_comb begin
        w_ack      = '0;
        w_done_hot = '0;
        for (int i = 0; i < NB_CH; i++) begin
            w_ack[i]      = w_handshake && (r_trans_id == IDW'(i));
            w_done_hot[i] = trans_done_i && (trans_done_id_i == IDW'(i));
        end
    end

    // An out-of-range index decodes to no channel, so it is spurious too.
    assign w_done_valid   = |(w_done_hot & r_outstanding);
    assign w_spurious_nxt = trans_done_i && !w_done_valid;

    // State register and registered outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state       <= ST_IDLE;
            r_trans_id    <= '0;
            r_rr_ptr      <= '0;
            r_trans_valid <= 1'b0;
            r_outstanding <= '0;
            r_spurious    <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_trans_id    <= w_id_nxt;
            r_rr_ptr      <= w_rr_nxt;
            r_trans_valid <= w_valid_nxt;
            r_outstanding <= w_out_nxt;
            r_spurious    <= w_spurious_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_found) begin
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (trans_ready_i) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Output / datapath next values
    always_comb begin
        w_valid_nxt = (w_state_nxt == ST_ISSUE);
        w_id_nxt    = r_trans_id;
        if ((r_state == ST_IDLE) && w_pick_found) begin
            w_id_nxt = w_pick;
        end

        w_rr_sum = {1'b0, r_trans_id} + (IDW+1)'(1);
        if (w_rr_sum == LP_NB_CH) begin
            w_rr_sum = '0;
        end
        w_rr_nxt = w_handshake ? w_rr_sum[IDW-1:0] : r_rr_ptr;

        // Done and handshake never target the same channel, so clear and set
        // can be applied together.
        w_out_nxt = (r_outstanding & ~w_done_hot) | w_ack;
    end

    assign ch_ack_o        = w_ack;
    assign trans_valid_o   = r_trans_valid;
    assign trans_id_o      = r_trans_id;
    assign outstanding_o   = r_outstanding;
    assign spurious_done_o = r_spurious;

endmodule

// File: tb/tb_udma_hyper_ch_sched.sv
module tb_udma_hyper_ch_sched;

    localparam int NB_CH    = 4;
    localparam int ID_WIDTH = 2;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic [3:0]       ch_req_i;
    logic [3:0]       ch_ack_o;
    logic [3:0]       proc_id_vec_i;
    logic             trans_valid_o;
    logic             trans_ready_i;
    logic [2:0]       trans_id_o;
    logic             trans_done_i;
    logic [2:0]       trans_done_id_i;
    logic [3:0]       outstanding_o;
    logic             spurious_done_o;

    udma_hyper_ch_sched #(.NB_CH(NB_CH), .ID_WIDTH(ID_WIDTH)) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .ch_req_i        (ch_req_i),
        .ch_ack_o        (ch_ack_o),
        .proc_id_vec_i   (proc_id_vec_i),
        .trans_valid_o   (trans_valid_o),
        .trans_ready_i   (trans_ready_i),
        .trans_id_o      (trans_id_o),
        .trans_done_i    (trans_done_i),
        .trans_done_id_i (trans_done_id_i),
        .outstanding_o   (outstanding_o),
        .spurious_done_o (spurious_done_o)
    );

    always #5 clk_i = ~clk_i;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        bit       rst;
        bit [3:0] req;
        bit [3:0] busy;
        bit       rdy;
        bit       dn;
        bit [2:0] did;
        bit [3:0] e_ack;
        bit       e_valid;
        bit [2:0] e_id;
        bit [3:0] e_out;
        bit       e_spur;
    } vec_t;

    vec_t tv[$];

    function automatic void add(bit r, bit [3:0] rq, bit [3:0] bs, bit rd, bit dn,
                                bit [2:0] di, bit [3:0] ea, bit ev, bit [2:0] eid,
                                bit [3:0] eo, bit es);
        vec_t v;
        v.rst = r; v.req = rq; v.busy = bs; v.rdy = rd; v.dn = dn; v.did = di;
        v.e_ack = ea; v.e_valid = ev; v.e_id = eid; v.e_out = eo; v.e_spur = es;
        tv.push_back(v);
    endfunction

    // Reference model: a pending offer, a set of outstanding channels and a
    // round-robin start position, advanced once per clock.
    bit m_pend;
    int m_id;
    int m_out;
    int m_rr;
    bit m_spur;

    task automatic model_step(input bit r, input int req, input int busy,
                              input bit rdy, input bit dn, input int did);
        int old_out;
        int elig;
        int c;
        if (r) begin
            m_pend = 0; m_id = 0; m_out = 0; m_rr = 0; m_spur = 0;
        end else begin
            old_out = m_out;
            m_spur  = 0;
            if (dn) begin
                if (did < NB_CH && ((old_out >> did) & 1) == 1)
                    m_out = m_out & ~(1 << did);
                else
                    m_spur = 1;
            end
            if (m_pend && rdy) begin
                m_out  = m_out | (1 << m_id);
                m_rr   = (m_id + 1) % NB_CH;
                m_pend = 0;
            end else if (!m_pend) begin
                elig = req & ~busy & ~old_out & 15;
                for (int k = 0; k < NB_CH; k++) begin
                    c = (m_rr + k) % NB_CH;
                    if (!m_pend && ((elig >> c) & 1) == 1) begin
                        m_pend = 1;
                        m_id   = c;
                    end
                end
            end
        end
    endtask

    initial begin
        rst_i = 1'b1; ch_req_i = '0; proc_id_vec_i = '0; trans_ready_i = 1'b0;
        trans_done_i = 1'b0; trans_done_id_i = '0;
        @(posedge clk_i); #1;

        //   rst req   busy  rdy dn did  ack   v  id  out   spur
        add(1, 4'h0, 4'h0, 0, 0, 0,  4'h0, 0, 0, 4'h0, 0);
        // full request, always ready: IDs 0..3 every second cycle
        add(0, 4'hF, 4'h0, 1, 0, 0,  4'h0, 1, 0, 4'h0, 0);
        add(0, 4'hF, 4'h0, 1, 0, 0,  4'h1, 0, 0, 4'h1, 0);
        add(0, 4'hF, 4'h0, 1, 0, 0,  4'h0, 1, 1, 4'h1, 0);
        add(0, 4'hF, 4'h0, 1, 0, 0,  4'h2, 0, 0, 4'h3, 0);
        add(0, 4'hF, 4'h0, 1, 0, 0,  4'h0, 1, 2, 4'h3, 0);
        add(0, 4'hF, 4'h0, 1, 0, 0,  4'h4, 0, 0, 4'h7, 0);
        add(0, 4'hF, 4'h0, 1, 0, 0,  4'h0, 1, 3, 4'h7, 0);
        add(0, 4'hF, 4'h0, 1, 0, 0,  4'h8, 0, 0, 4'hF, 0);
        add(0, 4'hF, 4'h0, 1, 0, 0,  4'h0, 0, 0, 4'hF, 0);
        // busy channel 0 skipped, ID 2 chosen
        add(1, 4'h0, 4'h0, 0, 0, 0,  4'h0, 0, 0, 4'h0, 0);
        add(0, 4'h5, 4'h1, 0, 0, 0,  4'h0, 1, 2, 4'h0, 0);
        add(0, 4'h5, 4'h1, 1, 0, 0,  4'h4, 0, 0, 4'h4, 0);
        add(0, 4'h0, 4'h0, 0, 0, 0,  4'h0, 0, 0, 4'h4, 0);
        // ID 1 held through 5 not-ready cycles while req drops and busy rises
        add(0, 4'h2, 4'h0, 0, 0, 0,  4'h0, 1, 1, 4'h4, 0);
        for (int i = 0; i < 5; i++)
            add(0, 4'h0, 4'h2, 0, 0, 0,  4'h0, 1, 1, 4'h4, 0);
        add(0, 4'h0, 4'h2, 1, 0, 0,  4'h2, 0, 0, 4'h6, 0);
        // done id 2, then done id 1 together with handshake id 3
        add(0, 4'h0, 4'h0, 0, 1, 2,  4'h0, 0, 0, 4'h2, 0);
        add(0, 4'h8, 4'h0, 0, 0, 0,  4'h0, 1, 3, 4'h2, 0);
        add(0, 4'h8, 4'h0, 1, 1, 1,  4'h8, 0, 0, 4'h8, 0);
        // spurious done: not outstanding, then out of range
        add(0, 4'h0, 4'h0, 0, 1, 2,  4'h0, 0, 0, 4'h8, 1);
        add(0, 4'h0, 4'h0, 0, 1, 5,  4'h0, 0, 0, 4'h8, 1);
        add(0, 4'h0, 4'h0, 0, 0, 0,  4'h0, 0, 0, 4'h8, 0);
        // reset during ISSUE with two outstanding
        add(1, 4'h0, 4'h0, 0, 0, 0,  4'h0, 0, 0, 4'h0, 0);
        add(0, 4'h1, 4'h0, 0, 0, 0,  4'h0, 1, 0, 4'h0, 0);
        add(0, 4'h1, 4'h0, 1, 0, 0,  4'h1, 0, 0, 4'h1, 0);
        add(0, 4'h2, 4'h0, 0, 0, 0,  4'h0, 1, 1, 4'h1, 0);
        add(0, 4'h2, 4'h0, 1, 0, 0,  4'h2, 0, 0, 4'h3, 0);
        add(0, 4'h4, 4'h0, 0, 0, 0,  4'h0, 1, 2, 4'h3, 0);
        add(1, 4'h4, 4'h0, 1, 0, 0,  4'h0, 0, 0, 4'h0, 0);
        add(0, 4'h0, 4'h0, 1, 0, 0,  4'h0, 0, 0, 4'h0, 0);
        // round-robin pointer back at 0 after reset
        add(0, 4'hF, 4'h0, 0, 0, 0,  4'h0, 1, 0, 4'h0, 0);

        foreach (tv[i]) begin
            rst_i = tv[i].rst; ch_req_i = tv[i].req; proc_id_vec_i = tv[i].busy;
            trans_ready_i = tv[i].rdy; trans_done_i = tv[i].dn;
            trans_done_id_i = tv[i].did;
            #1;
            chk($sformatf("vec%0d ack", i), int'(ch_ack_o), int'(tv[i].e_ack));
            @(posedge clk_i); #1;
            chk($sformatf("vec%0d valid", i), int'(trans_valid_o), int'(tv[i].e_valid));
            chk($sformatf("vec%0d outstanding", i), int'(outstanding_o), int'(tv[i].e_out));
            chk($sformatf("vec%0d spurious", i), int'(spurious_done_o), int'(tv[i].e_spur));
            if (tv[i].e_valid || tv[i].rst)
                chk($sformatf("vec%0d id", i), int'(trans_id_o), int'(tv[i].e_id));
        end

        // Randomized phase against the reference model
        for (int cyc = 0; cyc < 3000; cyc++) begin
            int exp_ack;
            rst_i         = (cyc == 0) || ($urandom_range(199) == 0);
            ch_req_i      = 4'($urandom);
            proc_id_vec_i = 4'($urandom & $urandom);
            trans_ready_i = 1'($urandom_range(1));
            trans_done_i  = ($urandom_range(3) == 0);
            trans_done_id_i = ($urandom_range(4) == 0) ? 3'($urandom_range(7, 4))
                                                       : 3'($urandom_range(3));
            exp_ack = (m_pend && trans_ready_i && !rst_i) ? (1 << m_id) : 0;
            #1;
            chk("rnd ack", int'(ch_ack_o), exp_ack);
            model_step(rst_i, int'(ch_req_i), int'(proc_id_vec_i), trans_ready_i,
                       trans_done_i, int'(trans_done_id_i));
            @(posedge clk_i); #1;
            chk("rnd valid", int'(trans_valid_o), int'(m_pend));
            chk("rnd outstanding", int'(outstanding_o), m_out);
            chk("rnd spurious", int'(spurious_done_o), int'(m_spur));
            if (m_pend)
                chk("rnd id", int'(trans_id_o), m_id);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
